adbg_biu_arbiter: RTL and testbench

- Shares one debug bus interface unit (BIU) between NUM_REQ debug-side requesters, e.g. the system-bus debug module and the CPU debug module.
- Each requester sees an ordinary BIU handshake: strobe when ready, ready drops, ready returns with data and error.
- The block queues one pending access per requester and forwards them one at a time, round-robin, to the downstream BIU strobe/ready port.
- Sits in the TCK/debug clock domain, between the debug modules and the bus BIU.

---
 rtl/adbg_biu_arbiter.sv | 166 ++++++++++++++++
 tb/tb_adbg_biu_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adbg_biu_arbiter.sv
// adbg_biu_arbiter: shares one debug BIU between NUM_REQ requesters, one pending access per requester, RR or fixed priority.
// Define ADBG_BIU_ARB_TIMEOUT_EN for a watchdog that completes a stalled access with an error and drains the late result.
module adbg_biu_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           biu_clk,
  input  logic                           biu_rst,
  input  logic [NUM_REQ-1:0]             req_strb,
  input  logic [NUM_REQ-1:0]             req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_di,
  input  logic [NUM_REQ*4-1:0]           req_word_size,
  output logic [NUM_REQ*DATA_WIDTH-1:0]  req_do,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic [NUM_REQ-1:0]             req_err,
  output logic                           biu_strb,
  output logic                           biu_rw,
  output logic [ADDR_WIDTH-1:0]          biu_addr,
  output logic [DATA_WIDTH-1:0]          biu_di,
  output logic [3:0]                     biu_word_size,
  input  logic [DATA_WIDTH-1:0]          biu_do,
  input  logic                           biu_rdy,
  input  logic                           biu_err
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef ADBG_BIU_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DRAIN} state_t;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             do_tmo;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
`endif

  state_t state_q, state_d;

  logic                  slot_rw   [NUM_REQ];
  logic [ADDR_WIDTH-1:0] slot_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_di   [NUM_REQ];
  logic [3:0]            slot_ws   [NUM_REQ];
  logic [NUM_REQ-1:0]    pend;
  logic [IDXW-1:0]       last_grant, grant, win;
  logic                  win_vld, do_issue, do_done;

  // Search starts just after the last served requester so every pending slot is reached within NUM_REQ grants.
  always_comb begin : arb
    int cand;
    cand    = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (FIXED_PRIO != 0) begin
        cand = k;
      end else begin
        cand = int'(last_grant) + 1 + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      end
      if (!win_vld && pend[IDXW'(cand)]) begin
        win     = IDXW'(cand);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    do_issue = 1'b0;
    do_done  = 1'b0;
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
    do_tmo   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Waiting for biu_rdy also lets a transfer orphaned by reset drain before anything new is issued.
        if (win_vld && biu_rdy) begin
          do_issue = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (biu_rdy) begin
          do_done = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          do_tmo  = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (biu_rdy) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge biu_clk) begin
    if (biu_rst) begin
      state_q       <= ST_IDLE;
      pend          <= '0;
      req_rdy       <= '1;
      req_do        <= '0;
      req_err       <= '0;
      biu_strb      <= 1'b0;
      biu_rw        <= 1'b0;
      biu_addr      <= '0;
      biu_di        <= '0;
      biu_word_size <= '0;
      grant         <= '0;
      last_grant    <= IDXW'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      biu_strb <= do_issue;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_strb[i] && req_rdy[i]) begin
          slot_rw[i]   <= req_rw[i];
          slot_addr[i] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          slot_di[i]   <= req_di[i*DATA_WIDTH +: DATA_WIDTH];
          slot_ws[i]   <= req_word_size[i*4 +: 4];
          pend[i]      <= 1'b1;
          req_rdy[i]   <= 1'b0;
        end
      end
      if (do_issue) begin
        grant         <= win;
        biu_rw        <= slot_rw[win];
        biu_addr      <= slot_addr[win];
        biu_di        <= slot_di[win];
        biu_word_size <= slot_ws[win];
      end
      // The granted slot has req_rdy low, so completion never collides with an accept of the same slot.
      if (do_done) begin
        req_do[grant*DATA_WIDTH +: DATA_WIDTH] <= biu_do;
        req_err[grant] <= biu_err;
        pend[grant]    <= 1'b0;
        req_rdy[grant] <= 1'b1;
        last_grant     <= grant;
      end
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
      if (do_tmo) begin
        req_do[grant*DATA_WIDTH +: DATA_WIDTH] <= '0;
        req_err[grant] <= 1'b1;
        pend[grant]    <= 1'b0;
        req_rdy[grant] <= 1'b1;
        last_grant     <= grant;
      end
`endif
    end
  end

`ifdef ADBG_BIU_ARB_TIMEOUT_EN
  always_ff @(posedge biu_clk) begin
    if (biu_rst || state_q != ST_WAIT) tmo_cnt <= '0;
    else                               tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`endif

endmodule

// File: tb/tb_adbg_biu_arbiter.sv
// Directed self-checking bench for adbg_biu_arbiter: a round-robin instance plus a fixed-priority instance.
module tb_adbg_biu_arbiter;
  logic biu_clk = 1'b0;
  always #5 biu_clk = ~biu_clk;

  logic        biu_rst;
  logic [1:0]  req_strb, req_rw;
  logic [63:0] req_addr, req_di;
  logic [7:0]  req_word_size;
  logic [63:0] req_do;
  logic [1:0]  req_rdy, req_err;
  logic        biu_strb, biu_rw;
  logic [31:0] biu_addr, biu_di;
  logic [3:0]  biu_word_size;
  logic [31:0] biu_do;
  logic        biu_rdy, biu_err;

  logic [1:0]  f_strb;
  logic [63:0] f_req_do;
  logic [1:0]  f_req_rdy, f_req_err;
  logic        f_biu_strb, f_biu_rw, f_biu_rdy;
  logic [31:0] f_biu_addr, f_biu_di;
  logic [3:0]  f_biu_ws;

  int checks   = 0;
  int failures = 0;

  adbg_biu_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(0), .TIMEOUT_CYCLES(16)) dut (
    .biu_clk(biu_clk), .biu_rst(biu_rst),
    .req_strb(req_strb), .req_rw(req_rw), .req_addr(req_addr), .req_di(req_di),
    .req_word_size(req_word_size), .req_do(req_do), .req_rdy(req_rdy), .req_err(req_err),
    .biu_strb(biu_strb), .biu_rw(biu_rw), .biu_addr(biu_addr), .biu_di(biu_di),
    .biu_word_size(biu_word_size), .biu_do(biu_do), .biu_rdy(biu_rdy), .biu_err(biu_err)
  );

  adbg_biu_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1), .TIMEOUT_CYCLES(16)) dut_fp (
    .biu_clk(biu_clk), .biu_rst(biu_rst),
    .req_strb(f_strb), .req_rw(req_rw), .req_addr(req_addr), .req_di(req_di),
    .req_word_size(req_word_size), .req_do(f_req_do), .req_rdy(f_req_rdy), .req_err(f_req_err),
    .biu_strb(f_biu_strb), .biu_rw(f_biu_rw), .biu_addr(f_biu_addr), .biu_di(f_biu_di),
    .biu_word_size(f_biu_ws), .biu_do(32'h0), .biu_rdy(f_biu_rdy), .biu_err(1'b0)
  );

  task automatic tick();
    @(posedge biu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_strb(input string tag);
    int n = 0;
    while (biu_strb !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, biu_strb}, 64'd1);
  endtask

  initial begin
    logic seen;
    biu_rst = 1'b1; req_strb = '0; req_rw = '0; req_addr = '0; req_di = '0;
    req_word_size = 8'h44; biu_do = '0; biu_rdy = 1'b1; biu_err = 1'b0;
    f_strb = '0; f_biu_rdy = 1'b1;
    tick(); tick();
    biu_rst = 1'b0;
    chk("reset_rdy",  req_rdy,  2'b11);
    chk("reset_do",   req_do,   64'd0);
    chk("reset_err",  req_err,  2'b00);
    chk("reset_strb", biu_strb, 1'b0);

    // single read, requester 0
    req_strb = 2'b01; req_rw = 2'b01; req_addr[31:0] = 32'h1000;
    tick();
    req_strb = 2'b00;
    chk("t1_rdy_drop", req_rdy, 2'b10);
    tick();
    chk("t1_strb", biu_strb, 1'b1);
    chk("t1_addr", biu_addr, 32'h1000);
    chk("t1_rw",   biu_rw,   1'b1);
    chk("t1_ws",   biu_word_size, 4'h4);
    biu_rdy = 1'b0;
    tick();
    chk("t1_strb_one_cycle", biu_strb, 1'b0);
    tick();
    chk("t1_rdy_wait", req_rdy, 2'b10);
    biu_rdy = 1'b1; biu_do = 32'hDEADBEEF;
    tick();
    chk("t1_rdy_back", req_rdy, 2'b11);
    chk("t1_do", req_do[31:0], 32'hDEADBEEF);

    // simultaneous writes after a fresh reset
    biu_rst = 1'b1; tick(); biu_rst = 1'b0;
    req_strb = 2'b11; req_rw = 2'b00; req_addr = {32'h20, 32'h10}; req_di = {32'hB2, 32'hA1};
    tick();
    req_strb = 2'b00;
    chk("t2_both_latched", req_rdy, 2'b00);
    tick();
    chk("t2_strb0", biu_strb, 1'b1);
    chk("t2_addr0", biu_addr, 32'h10);
    chk("t2_di0",   biu_di,   32'hA1);
    biu_rdy = 1'b0; tick(); biu_rdy = 1'b1; tick();
    chk("t2_rdy_after0", req_rdy, 2'b01);
    chk("t2_dead_cycle", biu_strb, 1'b0);
    tick();
    chk("t2_strb1", biu_strb, 1'b1);
    chk("t2_addr1", biu_addr, 32'h20);
    biu_rdy = 1'b0; tick(); biu_rdy = 1'b1; tick();
    chk("t2_rdy_after1", req_rdy, 2'b11);

    // continuous strobing, round-robin alternation
    req_addr = {32'hB0, 32'hA0}; req_rw = 2'b11; req_strb = 2'b11;
    tick();
    for (int n = 0; n < 8; n++) begin
      wait_strb("rr_strb");
      chk("rr_order", biu_addr, (n % 2 == 0) ? 32'hA0 : 32'hB0);
      biu_rdy = 1'b0; tick();
      biu_rdy = 1'b1; biu_do = 32'h100 + n; tick();
      chk("rr_do", (n % 2 == 0) ? req_do[31:0] : req_do[63:32], 32'h100 + n);
    end
    req_strb = 2'b00;

    // requester 0 was re-latched during the last transfer; reset while it sits in WAIT
    wait_strb("rst_pre_strb");
    chk("rst_pre_addr", biu_addr, 32'hA0);
    biu_rdy = 1'b0; tick(); tick();
    biu_rst = 1'b1; tick(); biu_rst = 1'b0;
    chk("rst_rdy",  req_rdy,  2'b11);
    chk("rst_err",  req_err,  2'b00);
    chk("rst_strb", biu_strb, 1'b0);
    req_strb = 2'b10;
    tick();
    req_strb = 2'b00;
    chk("rst_accept", req_rdy, 2'b01);
    tick();
    chk("rst_hold_a", biu_strb, 1'b0);
    tick();
    chk("rst_hold_b", biu_strb, 1'b0);
    biu_rdy = 1'b1;
    tick();
    chk("rst_issue", biu_strb, 1'b1);
    chk("rst_addr",  biu_addr, 32'hB0);

    // that read completes with a bus error
    biu_rdy = 1'b0; tick();
    biu_rdy = 1'b1; biu_err = 1'b1; biu_do = 32'h5555; tick();
    biu_err = 1'b0;
    chk("err_flag", req_err, 2'b10);
    chk("err_rdy",  req_rdy, 2'b11);
    chk("err_do",   req_do[63:32], 32'h5555);
    req_strb = 2'b10;
    tick();
    req_strb = 2'b00;
    wait_strb("clean_strb");
    biu_rdy = 1'b0; tick();
    biu_rdy = 1'b1; biu_do = 32'h77; tick();
    chk("clean_err", req_err, 2'b00);
    chk("clean_do",  req_do,  {32'h77, 32'h0});

`ifdef ADBG_BIU_ARB_TIMEOUT_EN
    req_addr[31:0] = 32'hE0;
    req_strb = 2'b01; tick(); req_strb = 2'b00;
    wait_strb("tmo_strb");
    biu_rdy = 1'b0; tick();
    repeat (15) tick();
    chk("tmo_not_yet", req_rdy, 2'b10);
    tick();
    chk("tmo_rdy", req_rdy, 2'b11);
    chk("tmo_err", req_err, 2'b01);
    chk("tmo_do",  req_do[31:0], 32'h0);
    req_strb = 2'b01; tick(); req_strb = 2'b00;
    seen = 1'b0;
    for (int n = 0; n < 22; n++) begin
      tick();
      if (biu_strb) seen = 1'b1;
    end
    chk("tmo_drain_quiet", seen, 1'b0);
    biu_rdy = 1'b1;
    wait_strb("tmo_after_drain");
    biu_rdy = 1'b0; tick();
    biu_rdy = 1'b1; biu_do = 32'h99; tick();
    chk("tmo_next_do",  req_do[31:0], 32'h99);
    chk("tmo_next_err", req_err, 2'b00);
`endif

    // fixed priority: after serving 0, a simultaneous 0/1 request still goes to 0 first
    biu_rst = 1'b1; tick(); biu_rst = 1'b0;
    req_addr = {32'hD0, 32'hC0};
    f_strb = 2'b01; tick(); f_strb = 2'b00;
    tick();
    chk("fp_first", f_biu_addr, 32'hC0);
    f_biu_rdy = 1'b0; tick(); f_biu_rdy = 1'b1; tick();
    f_strb = 2'b11; tick(); f_strb = 2'b00;
    tick();
    chk("fp_strb",  f_biu_strb, 1'b1);
    chk("fp_prio0", f_biu_addr, 32'hC0);
    f_biu_rdy = 1'b0; tick(); f_biu_rdy = 1'b1; tick();
    tick();
    chk("fp_then1", f_biu_addr, 32'hD0);
    f_biu_rdy = 1'b0; tick(); f_biu_rdy = 1'b1; tick();
    chk("fp_rdy",  f_req_rdy, 2'b11);
    chk("fp_err",  f_req_err, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
